// File: rtl/keypad_scanner_if.sv
// Key-event interface between the keypad scanner (master) and the calculator datapath (slave).
// newkey is a one-cycle valid strobe with no ready: the consumer must take keycode in that cycle.
// keycode then holds until the next newkey; key_down marks the accepted key as still held.
interface keypad_scanner_if;
  logic [4:0] keycode;
  logic       newkey;
  logic       key_down;

  modport master (
    output keycode,
    output newkey,
    output key_down
  );

  modport slave (
    input keycode,
    input newkey,
    input key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 6x4 matrix keypad scanner: drives one column at a time, synchronises and debounces the
// active-low rows, and emits one calculator key code per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        row_n,
  output logic [5:0]        col_n,
  keypad_scanner_if.master  key,
  output logic [1:0]        dbg_state_o
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    row_meta_q;
  logic [3:0]    rs_q;
  logic [2:0]    col_q;
  logic [1:0]    row_q;
  logic [CW-1:0] cnt_q;
  logic [4:0]    keycode_q;
  logic          newkey_q;
  logic          key_down_q;

  logic [2:0]    col_d;
  logic [1:0]    row_d;
  logic [4:0]    keycode_d;
  logic          any_low;

  function automatic logic [4:0] encode(input logic [2:0] c, input logic [1:0] r);
    logic [4:0] code;
    code = 5'b00000;
    case (c)
      3'd4: begin
        case (r)
          2'd0: code = 5'b01011; // ADD
          2'd1: code = 5'b01010; // SUB
          2'd2: code = 5'b01001; // MULTI
          2'd3: code = 5'b00011; // EQUALS
          default: code = 5'b00000;
        endcase
      end
      3'd5: begin
        case (r)
          2'd0: code = 5'b00001; // SQR
          2'd1: code = 5'b00010; // CH_SIGN
          2'd2: code = 5'b01100; // CE
          2'd3: code = 5'b00100; // CA
          default: code = 5'b00000;
        endcase
      end
      default: code = {1'b1, c[1:0], r};
    endcase
    return code;
  endfunction

  // Lowest-index low row wins when several keys in the column are down.
  always_comb begin
    row_d = 2'd3;
    if (!rs_q[0])      row_d = 2'd0;
    else if (!rs_q[1]) row_d = 2'd1;
    else if (!rs_q[2]) row_d = 2'd2;
    else               row_d = 2'd3;
  end

  assign any_low   = ~&rs_q;
  assign col_d     = (col_q == 3'd5) ? 3'd0 : col_q + 3'd1;
  assign keycode_d = encode(col_q, row_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= row_n;
      rs_q       <= row_meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_SCAN;
      col_q      <= 3'd0;
      row_q      <= 2'd0;
      cnt_q      <= '0;
      keycode_q  <= 5'b00000;
      newkey_q   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      newkey_q <= 1'b0;
      case (state_q)
        ST_SCAN: begin
          if (cnt_q == DWELL_LAST) begin
            cnt_q <= '0;
            if (any_low) begin
              row_q   <= row_d;
              state_q <= ST_DEBOUNCE;
            end else begin
              col_q <= col_d;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DEBOUNCE: begin
          if (rs_q[row_q]) begin
            cnt_q   <= '0;
            col_q   <= col_d;
            state_q <= ST_SCAN;
          end else if (cnt_q == DEB_LAST) begin
            // Outputs are registered here so they show during the EMIT cycle itself.
            cnt_q      <= '0;
            keycode_q  <= keycode_d;
            newkey_q   <= 1'b1;
            key_down_q <= 1'b1;
            state_q    <= ST_EMIT;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_EMIT: begin
          cnt_q   <= '0;
          state_q <= ST_RELEASE;
        end
        ST_RELEASE: begin
          // Only column c is driven, so keys elsewhere cannot hold this off.
          if (any_low) begin
            cnt_q <= '0;
          end else if (cnt_q == DEB_LAST) begin
            cnt_q      <= '0;
            key_down_q <= 1'b0;
            col_q      <= col_d;
            state_q    <= ST_SCAN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign col_n        = ~(6'b000001 << col_q);
  assign key.keycode  = keycode_q;
  assign key.newkey   = newkey_q;
  assign key.key_down = key_down_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model drives rows from the pressed-key matrix,
// a negedge monitor scores every newkey against an expected-code queue.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
  localparam logic [1:0] S_SCAN = 2'd0;
  localparam logic [1:0] S_DEB  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd3;

  // Hand-written code table, index c*4+r.
  localparam logic [4:0] CODE_TBL [24] = '{
    5'b10000, 5'b10001, 5'b10010, 5'b10011,
    5'b10100, 5'b10101, 5'b10110, 5'b10111,
    5'b11000, 5'b11001, 5'b11010, 5'b11011,
    5'b11100, 5'b11101, 5'b11110, 5'b11111,
    5'b01011, 5'b01010, 5'b01001, 5'b00011,
    5'b00001, 5'b00010, 5'b01100, 5'b00100
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [5:0] col_n;
  logic [1:0] dbg_state;
  logic [3:0] press_mask [6];

  keypad_scanner_if key_if ();

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .key         (key_if),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Physical keypad: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int i = 0; i < 6; i++) begin
      if (!col_n[i]) row_n = row_n & ~press_mask[i];
    end
  end

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [4:0] exp_q[$];
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse = -1000;
  int deb_start = 0;
  logic [1:0] prev_state = 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    check("col_onehot", 32'($countones(~col_n)), 32'd1);
    if (dbg_state == S_DEB && prev_state == S_SCAN) deb_start = cyc;
    prev_state = dbg_state;
    if (key_if.newkey) begin
      pulse_cnt++;
      check("pulse_gap", 32'((cyc - last_pulse) >= (2 * DEB + 1)), 32'd1);
      check("press_latency", 32'(cyc - deb_start), 32'(DEB));
      check("key_down_at_pulse", 32'(key_if.key_down), 32'd1);
      last_pulse = cyc;
      if (exp_q.size() == 0) check("newkey_unexpected", 32'(key_if.newkey), 32'd0);
      else check("sb_keycode", 32'(key_if.keycode), 32'(exp_q.pop_front()));
    end
  end

  // Driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_pulse(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (key_if.newkey) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_key_up(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (!key_if.key_down) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (dbg_state == st) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  task automatic tap_key(input int c, input int r, input logic [4:0] code);
    logic [5:0] exp_col;
    exp_col = ~(6'b000001 << ((c == 5) ? 0 : c + 1));
    exp_q.push_back(code);
    press_mask[c][r] = 1'b1;
    wait_pulse("tap_pulse", 200);
    check("tap_keycode", 32'(key_if.keycode), 32'(code));
    cycles(3);
    press_mask[c][r] = 1'b0;
    wait_key_up("tap_release", 60);
    check("tap_next_col", 32'(col_n), 32'(exp_col));
  endtask

  // Stimulus
  int pc;
  logic [5:0] seen_cols;

  initial begin
    for (int i = 0; i < 6; i++) press_mask[i] = 4'h0;
    rst = 1'b1;
    cycles(3);
    check("rst_col_n", 32'(col_n), 32'h3E);
    check("rst_keycode", 32'(key_if.keycode), 32'h00);
    check("rst_newkey", 32'(key_if.newkey), 32'd0);
    check("rst_key_down", 32'(key_if.key_down), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(S_SCAN));
    rst = 1'b0;
    cycles(1);
    check("dwell_col0", 32'(col_n), 32'h3E);

    // Bounce at (4,1): never 8 stable low cycles, so nothing is accepted.
    pc = pulse_cnt;
    for (int k = 0; k < 6; k++) begin
      press_mask[4][1] = 1'b1;
      cycles(5);
      press_mask[4][1] = 1'b0;
      cycles(1);
    end
    cycles(12);
    check("bounce_no_pulse", 32'(pulse_cnt), 32'(pc));
    check("bounce_keycode", 32'(key_if.keycode), 32'h00);
    check("bounce_state", 32'(dbg_state), 32'(S_SCAN));
    seen_cols = 6'h00;
    for (int k = 0; k < 30; k++) begin
      seen_cols = seen_cols | ~col_n;
      cycles(1);
    end
    check("bounce_scan_all_cols", 32'(seen_cols), 32'h3F);

    // Clean press at (1,3), exact release timing.
    pc = pulse_cnt;
    exp_q.push_back(5'b10111);
    press_mask[1][3] = 1'b1;
    wait_pulse("p13_pulse", 200);
    check("p13_keycode", 32'(key_if.keycode), 32'h17);
    check("p13_col_held", 32'(col_n), 32'h3D);
    cycles(20);
    check("p13_key_down_held", 32'(key_if.key_down), 32'd1);
    check("p13_col_held_late", 32'(col_n), 32'h3D);
    check("p13_state_rel", 32'(dbg_state), 32'(S_REL));
    check("p13_one_pulse", 32'(pulse_cnt), 32'(pc + 1));
    press_mask[1][3] = 1'b0;
    cycles(9);
    check("p13_key_down_pre", 32'(key_if.key_down), 32'd1);
    cycles(1);
    check("p13_key_down_clr", 32'(key_if.key_down), 32'd0);
    check("p13_resume_col2", 32'(col_n), 32'h3B);
    check("p13_state_scan", 32'(dbg_state), 32'(S_SCAN));

    // Long hold on CA (5,3): one pulse only, then (0,0).
    pc = pulse_cnt;
    exp_q.push_back(5'b00100);
    press_mask[5][3] = 1'b1;
    wait_pulse("ca_pulse", 200);
    cycles(180);
    check("ca_one_pulse", 32'(pulse_cnt), 32'(pc + 1));
    check("ca_keycode", 32'(key_if.keycode), 32'h04);
    check("ca_key_down", 32'(key_if.key_down), 32'd1);
    press_mask[5][3] = 1'b0;
    wait_key_up("ca_release", 60);
    tap_key(0, 0, 5'b10000);

    // Two keys in column 2: lowest row wins, partial release holds key_down.
    pc = pulse_cnt;
    exp_q.push_back(5'b11001);
    press_mask[2][1] = 1'b1;
    press_mask[2][3] = 1'b1;
    wait_pulse("dual_pulse", 200);
    check("dual_keycode", 32'(key_if.keycode), 32'h19);
    press_mask[2][1] = 1'b0;
    cycles(30);
    check("dual_key_down", 32'(key_if.key_down), 32'd1);
    check("dual_no_new_pulse", 32'(pulse_cnt), 32'(pc + 1));
    check("dual_state_rel", 32'(dbg_state), 32'(S_REL));
    press_mask[2][3] = 1'b0;
    wait_key_up("dual_release", 60);

    // Reset in the middle of debouncing (3,2).
    pc = pulse_cnt;
    press_mask[3][2] = 1'b1;
    wait_state("rstdeb_enter", S_DEB, 100);
    cycles(3);
    rst = 1'b1;
    #1;
    check("rstdeb_col_n", 32'(col_n), 32'h3E);
    check("rstdeb_keycode", 32'(key_if.keycode), 32'h00);
    check("rstdeb_newkey", 32'(key_if.newkey), 32'd0);
    check("rstdeb_key_down", 32'(key_if.key_down), 32'd0);
    check("rstdeb_state", 32'(dbg_state), 32'(S_SCAN));
    cycles(2);
    check("rstdeb_no_pulse", 32'(pulse_cnt), 32'(pc));
    rst = 1'b0;
    exp_q.push_back(5'b11110);
    wait_pulse("rstdeb_pulse", 200);
    check("rstdeb_keycode_after", 32'(key_if.keycode), 32'h1E);
    press_mask[3][2] = 1'b0;
    wait_key_up("rstdeb_release", 60);

    // Walk every key.
    for (int c = 0; c < 6; c++) begin
      for (int r = 0; r < 4; r++) begin
        tap_key(c, r, CODE_TBL[c * 4 + r]);
      end
    end

    cycles(5);
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix-keypad front end for the calculator. It drives the 6-column × 4-row keypad one column at a time, synchronises and debounces the row returns, and encodes each accepted key press into the 5-bit calculator key code. Each accepted press produces exactly one single-cycle `newkey` pulse, which is the producer side of the `keycode`/`newkey` interface consumed by the calculator datapath.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven while scanning; minimum 4.
- `DEBOUNCE_CYCLES`, default 100000: consecutive stable cycles required to accept a press or a release; minimum 2.
- `clk`, in, 1: system clock. One clock only.
- `rst`, in, 1: reset, asynchronous and active-high.
- `row_n`, in, 4: keypad rows, active-low (pulled up externally), asynchronous to `clk`.
- `col_n`, out, 6: column drive, active-low; exactly one bit is low at all times.
- `keycode`, out, 5: code of the last accepted key; holds until the next accepted key.
- `newkey`, out, 1: one-cycle pulse, asserted in the cycle `keycode` first shows the new value.
- `key_down`, out, 1: high from the acceptance of a press until its release is debounced.

## Operation
- Key position is (c, r) with column c in 0..5 and row r in 0..3.
- Digit keys (c ≤ 3): `keycode` = {1'b1, d[3:0]} with d = 4c + r, covering hex digits 0..F.
- Function keys in column 4, rows 0..3: ADD 01011, SUB 01010, MULTI 01001, EQUALS 00011.
- Function keys in column 5, rows 0..3: SQR 00001, CH_SIGN 00010, CE 01100, CA 00100.
- Row inputs pass through a 2-flop synchroniser. All decisions below use the synchronised value `rs`.
- FSM states:
  - SCAN: the dwell counter counts 0..SCAN_DIV-1 on the current column. On the last dwell cycle, `rs` is sampled.
    - If any bit of `rs` is low, latch r = lowest-index low row and c = current column, then go to DEBOUNCE.
    - Otherwise advance the column, wrapping 5 → 0.
  - DEBOUNCE: column c stays driven. The counter increments each cycle `rs[r]` is low.
    - If `rs[r]` goes high, clear the counter, advance the column and return to SCAN. No output.
    - When the count reaches DEBOUNCE_CYCLES, go to EMIT.
  - EMIT: lasts 1 cycle. Update `keycode`, pulse `newkey`, set `key_down`, go to RELEASE.
  - RELEASE: column c stays driven. Count consecutive cycles with `rs` == 4'b1111; any low bit clears the count.
    - At DEBOUNCE_CYCLES, clear `key_down`, advance the column and return to SCAN.
- Multiple simultaneous keys:
  - Same column: the lowest row wins.
  - Different columns: the first column reached in scan order wins.
  - No further key is accepted until every row in column c has released. Keys in other columns are invisible during RELEASE.
- Auto-repeat is not supported. A held key produces exactly one `newkey`.

## Timing
- Reset values:
  - state = SCAN, column 0 driven, so `col_n` = 6'b111110.
  - `keycode` = 5'b00000, `newkey` = 0, `key_down` = 0.
  - All counters and synchroniser flops = 0 / all-ones as appropriate: synchroniser flops reset to 1 (idle rows).
- Reset asserted in any state (including mid-DEBOUNCE or RELEASE) returns to the reset values immediately, with no `newkey`.
- Press latency: if the SCAN sample in cycle T detects the key and it stays stable, `newkey` is high in cycle T+1+DEBOUNCE_CYCLES. Worst case from the physical press adds 2 synchroniser cycles plus 6·SCAN_DIV cycles.
- `keycode` changes only in the EMIT cycle. It is registered, with no combinational path from `row_n`.
- Back-to-back `newkey` pulses are separated by at least 2·DEBOUNCE_CYCLES+1 cycles.
- `col_n` changes only on SCAN column advances. During DEBOUNCE, EMIT and RELEASE it is held on c.

## Test plan
- Use SCAN_DIV=4 and DEBOUNCE_CYCLES=8 for all scenarios.
- Clean press at (1,3) held for 40 cycles, then released:
  - one `newkey` pulse with `keycode`=10111;
  - `key_down` high from the pulse until 8 idle cycles after release;
  - column scan resumes at column 2.
- Bounce at (4,1): low for 5 cycles, high, then low for 5 cycles:
  - no `newkey`;
  - `keycode` stays 00000;
  - scan continues.
- Hold (5,3) for 200 cycles:
  - exactly one `newkey`, `keycode`=00100 (CA);
  - then press (0,0) → second pulse with `keycode`=10000.
- Press (2,1) and (2,3) together:
  - `keycode`=11001;
  - releasing only row 1 while row 3 is still held produces no new pulse and `key_down` stays 1.
- Assert `rst` mid-DEBOUNCE on (3,2):
  - outputs return to reset values in the same cycle (`col_n`=111110);
  - no pulse;
  - after release of `rst`, with the key still held, the press is accepted normally with `keycode`=11110.
- Walk all 24 keys in sequence:
  - each produces one pulse with the mapped code;
  - `col_n` is always one-hot-low.
